// File: rtl/upd_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : upd_arb_pkg
// Brief  : Shared constants and FSM state encoding for the RMW update arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
package upd_arb_pkg;

  localparam int ELEM_W = 48;
  localparam int WORD_W = 256;
  localparam int ADDR_W = 11;
  localparam int LANES  = 4;
  localparam int LANE_W = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARB   = 3'd1,
    ST_CAPT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_ERR   = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/lane_merge.sv
`default_nettype none
// ============================================================================
// Module : lane_merge
// Brief  : Replaces one 48-bit element lane of a 256-bit word; upper bits pass.
// Rev    : 1.0 - initial release
// ============================================================================
module lane_merge
  import upd_arb_pkg::*;
(
  input  logic [WORD_W-1:0] word_i,
  input  logic [LANE_W-1:0] lane_i,
  input  logic [ELEM_W-1:0] elem_i,
  output logic [WORD_W-1:0] merged_o
);

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign merged_o[k*ELEM_W +: ELEM_W] =
      (lane_i == LANE_W'(k)) ? elem_i : word_i[k*ELEM_W +: ELEM_W];
  end

  assign merged_o[WORD_W-1:LANES*ELEM_W] = word_i[WORD_W-1:LANES*ELEM_W];

endmodule
`default_nettype wire

// File: rtl/upd_rmw_arbiter.sv
`default_nettype none
// ============================================================================
// Module : upd_rmw_arbiter
// Brief  : Read-modify-write element updater sharing one read port with a
//          compute engine, with starvation-bounded arbitration.
// Rev    : 1.0 - initial release
// ============================================================================
module upd_rmw_arbiter
  import upd_arb_pkg::*;
#(
  parameter int ROW_WORDS    = 16,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [15:0]         X,
  input  logic [15:0]         Y,
  input  logic [ELEM_W-1:0]   NewElement,
  input  logic                comp_rd_req,
  input  logic [ADDR_W-1:0]   comp_rd_addr,
  output logic                comp_rd_gnt,
  output logic [ADDR_W-1:0]   ReadAddress1,
  input  logic [WORD_W-1:0]   ReadBus1,
  output logic                WE,
  output logic [ADDR_W-1:0]   WriteReq,
  output logic [WORD_W-1:0]   WriteBus,
  output logic                upd_done,
  output logic                upd_err
);

  localparam int          MAX_ROWS    = (2 ** ADDR_W) / ROW_WORDS;
  localparam int          MAX_COLS    = LANES * ROW_WORDS;
  localparam int          CNT_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [31:0] ROW_WORDS_U = 32'(ROW_WORDS);

  state_e              state_q;
  logic [CNT_W-1:0]    deny_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [LANE_W-1:0]   lane_q;
  logic [ELEM_W-1:0]   elem_q;
  logic [WORD_W-1:0]   word_q;

  logic [ADDR_W-1:0]   addr_d;
  logic [WORD_W-1:0]   merged_d;
  logic                req_bad;
  logic                upd_win;
  logic                hazard;

  assign addr_d  = ADDR_W'(32'(X) * ROW_WORDS_U + 32'(Y[15:2]));
  assign req_bad = (32'(X) >= 32'(MAX_ROWS)) || (32'(Y) >= 32'(MAX_COLS));

  // Compute has priority until the updater has been denied STARVE_LIMIT times.
  assign upd_win = !reset && (state_q == ST_ARB) &&
                   (!comp_rd_req || (deny_q == CNT_W'(STARVE_LIMIT)));
  assign hazard  = ((state_q == ST_CAPT) || (state_q == ST_WRITE)) &&
                   (comp_rd_addr == addr_q);

  assign comp_rd_gnt  = !reset && comp_rd_req && !upd_win && !hazard;
  assign ReadAddress1 = comp_rd_gnt ? comp_rd_addr :
                        upd_win     ? addr_q       : '0;

  assign upd_ready = !reset && (state_q == ST_IDLE);
  assign upd_err   = !reset && (state_q == ST_ERR);
  assign WE        = !reset && (state_q == ST_WRITE);
  assign upd_done  = WE;
  assign WriteReq  = WE ? addr_q : '0;
  assign WriteBus  = WE ? word_q : '0;

  lane_merge u_lane_merge (
    .word_i   (ReadBus1),
    .lane_i   (lane_q),
    .elem_i   (elem_q),
    .merged_o (merged_d)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      deny_q  <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      elem_q  <= '0;
      word_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (upd_valid) begin
            addr_q  <= addr_d;
            lane_q  <= Y[LANE_W-1:0];
            elem_q  <= NewElement;
            deny_q  <= '0;
            state_q <= req_bad ? ST_ERR : ST_ARB;
          end
        end
        ST_ARB: begin
          if (upd_win) begin
            deny_q  <= '0;
            state_q <= ST_CAPT;
          end else if (deny_q != CNT_W'(STARVE_LIMIT)) begin
            deny_q  <= deny_q + CNT_W'(1);
          end
        end
        // Read data for addr_q arrives this cycle, one cycle after the address.
        ST_CAPT: begin
          word_q  <= merged_d;
          state_q <= ST_WRITE;
        end
        ST_WRITE: state_q <= ST_IDLE;
        ST_ERR:   state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/upd_rmw_arbiter.md
UPD_RMW_ARBITER -- requirements
Module: upd_rmw_arbiter

Interface
REQ-001 SHALL have parameter ROW_WORDS, default 16, meaning 256-bit words per matrix row (4 elements/word, so 4*ROW_WORDS columns).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning consecutive denied arbitration cycles before the updater gets forced priority.
REQ-003 SHALL have one clock and a synchronous active-high reset: `clock` in, 1 bit, sole clock, rising edge; `reset` in, 1 bit, synchronous, active-high.
REQ-004 SHALL have `upd_valid` in, 1 bit: element-update request.
REQ-005 SHALL have `upd_ready` out, 1 bit: updater can accept a request.
REQ-006 SHALL have `X` in, 16 bits: target row.
REQ-007 SHALL have `Y` in, 16 bits: target column.
REQ-008 SHALL have `NewElement` in, 48 bits: complex element, {real[23:0], imag[23:0]}.
REQ-009 SHALL have `comp_rd_req` in, 1 bit: compute-engine read request.
REQ-010 SHALL have `comp_rd_addr` in, 11 bits: compute read address.
REQ-011 SHALL have `comp_rd_gnt` out, 1 bit: compute read granted this cycle.
REQ-012 SHALL have `ReadAddress1` out, 11 bits: shared memory read port address.
REQ-013 SHALL have `ReadBus1` in, 256 bits: read data, valid one cycle after the address.
REQ-014 SHALL have `WE` out, 1 bit: write enable.
REQ-015 SHALL have `WriteReq` out, 11 bits: write address.
REQ-016 SHALL have `WriteBus` out, 256 bits: write data.
REQ-017 SHALL have `upd_done` out, 1 bit: one-cycle pulse when the update is written.
REQ-018 SHALL have `upd_err` out, 1 bit: one-cycle pulse when an accepted update is out of range.

Function
REQ-019 SHALL compute word address = X*ROW_WORDS + Y[15:2] and lane = Y[1:0]; lane k occupies WriteBus bits [48k+47:48k].
REQ-020 SHALL reject an update with X >= 2048/ROW_WORDS or Y >= 4*ROW_WORDS: pulse upd_err the cycle after acceptance, no memory access, return to IDLE.
REQ-021 SHALL implement the FSM IDLE -> ARB -> CAPT -> WRITE -> IDLE; upd_ready=1 only in IDLE; the request is captured on upd_valid&upd_ready.
REQ-022 In ARB, compute SHALL win when comp_rd_req=1, except when the denied count reaches STARVE_LIMIT; the updater then wins that cycle and the count clears.
REQ-023 On an updater win, ReadAddress1 SHALL equal the update address and the FSM SHALL move to CAPT; otherwise it stays in ARB and the denied count increments, saturating.
REQ-024 ReadAddress1 SHALL be combinational: comp_rd_addr when comp_rd_gnt=1, the update address on an updater ARB win, and 0 otherwise.
REQ-025 In CAPT, the block SHALL register ReadBus1 with the target lane replaced by NewElement; all other lanes and bits [255:192] are preserved.
REQ-026 In WRITE, WE=1, WriteReq=address, WriteBus=merged word and upd_done=1 for exactly one cycle.
REQ-027 Best-case latency SHALL be: accept at t, ReadAddress1 at t+1, capture at t+2, WE/upd_done at t+3, upd_ready again at t+4.
REQ-028 comp_rd_gnt SHALL be 1 whenever comp_rd_req=1 and the read port is not used by the updater.
REQ-029 Hazard: comp_rd_gnt SHALL be 0 in CAPT or WRITE when comp_rd_addr equals the pending write address.
REQ-030 WE SHALL be 0 in every state other than WRITE.

Reset
REQ-031 While reset=1: state=IDLE, upd_ready=0, comp_rd_gnt=0, WE=0, WriteReq=0, WriteBus=0, upd_done=0, upd_err=0, ReadAddress1=0, denied count=0.
REQ-032 Reset mid-operation SHALL drop the pending update with no write; upd_ready SHALL return to 1 the first cycle after reset deasserts.

Structure
REQ-033 Package upd_arb_pkg SHALL hold the state enum and the constants ELEM_W=48, WORD_W=256, ADDR_W=11, LANES=4.
REQ-034 Sub-module lane_merge (combinational: word, lane, element -> merged word) SHALL be instantiated once.

Verification
REQ-035 Idle port, ROW_WORDS=16, X=2, Y=5, NewElement=48'hABCDEF_123456, ReadBus1 all-ones -> at t+3 WE=1, WriteReq=33, WriteBus lane1=ABCDEF123456, all other bits 1, upd_done=1.
REQ-036 comp_rd_req held high during an update -> comp_rd_gnt=1 for 8 cycles, then the updater wins one cycle (comp_rd_gnt=0) and the write completes 2 cycles later.
REQ-037 X=128 with ROW_WORDS=16 -> upd_err pulse at t+1, WE never asserts, upd_ready=1 at t+2.
REQ-038 comp_rd_addr equal to the pending address during CAPT/WRITE -> comp_rd_gnt=0 in those cycles, 1 in the cycle after WRITE.
REQ-039 reset asserted in CAPT -> WE stays 0, no upd_done, upd_ready=1 the cycle after reset deasserts.
